// File: rtl/msg_header_decoder.sv
// msg_header_decoder: decodes the parser output bus into header fields and
// per-message close status (byte count, length and framing errors).
// Optional feature: define MSG_HDR_STATS_EN to build the saturating
// closed-message and errored-message counters; otherwise those ports read 0.
module msg_header_decoder #(
    parameter int WordWidth = 64,
    parameter int Bits      = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 In_Valid,
    input  logic                 In_Start_Msg,
    input  logic                 In_End_Msg,
    input  logic [Bits-1:0]      In_Mod,
    input  logic [WordWidth-1:0] In_Data,
    output logic                 Hdr_Valid,
    output logic [7:0]           Hdr_Type,
    output logic [7:0]           Hdr_Flags,
    output logic [15:0]          Hdr_Length,
    output logic [31:0]          Hdr_SeqNum,
    output logic                 Msg_Done,
    output logic [15:0]          Msg_Bytes,
    output logic                 Msg_LenErr,
    output logic                 Msg_FrameErr,
    output logic                 Word_Drop,
    output logic [15:0]          Stat_MsgCount,
    output logic [15:0]          Stat_ErrCount
);

    typedef enum logic {IDLE, BODY} state_t;

    typedef struct packed {
        logic [15:0] bytes;
        logic        len_err;
        logic        frame_err;
    } close_t;

    state_t      state_q, state_n;
    logic [16:0] cnt_q, cnt_n;
    logic        pend_q, pend_n;
    close_t      pend_c_q, pend_c_n;

    logic        hdr_load;
    logic        drop_n;
    logic        c1_vld, c2_vld;
    close_t      c1, c2, start_c;
    logic        done_n;
    close_t      done_c;
    logic [16:0] word_bytes, sum;
    logic [15:0] sum_sat, cnt_sat, new_len;

    function automatic logic [15:0] sat16(input logic [16:0] v);
        return v[16] ? 16'hFFFF : v[15:0];
    endfunction

    assign new_len = In_Data[47:32];
    assign sum     = cnt_q + word_bytes;
    assign sum_sat = sat16(sum);
    assign cnt_sat = sat16(cnt_q);

    // Bytes carried by this word: 8, or the Mod count on an End word.
    always_comb begin
        word_bytes = 17'd8;
        if (In_End_Msg && (In_Mod != '0))
            word_bytes = {{(17-Bits){1'b0}}, In_Mod};
    end

    // Next-state and close-event generation; an aborting single-word Start
    // produces two closes, the second is held one cycle in the pending slot.
    always_comb begin
        state_n           = state_q;
        cnt_n             = cnt_q;
        hdr_load          = 1'b0;
        drop_n            = 1'b0;
        c1_vld            = 1'b0;
        c2_vld            = 1'b0;
        c1                = '0;
        c2                = '0;
        start_c           = '0;
        start_c.bytes     = sat16(word_bytes);
        start_c.len_err   = (sat16(word_bytes) != new_len);
        if (In_Valid) begin
            case (state_q)
                IDLE: begin
                    if (In_Start_Msg) begin
                        hdr_load = 1'b1;
                        cnt_n    = word_bytes;
                        if (In_End_Msg) begin
                            c1_vld = 1'b1;
                            c1     = start_c;
                        end else begin
                            state_n = BODY;
                        end
                    end else begin
                        drop_n = 1'b1;
                    end
                end
                BODY: begin
                    if (In_Start_Msg) begin
                        c1_vld       = 1'b1;
                        c1.bytes     = cnt_sat;
                        c1.len_err   = (cnt_sat != Hdr_Length);
                        c1.frame_err = 1'b1;
                        hdr_load     = 1'b1;
                        cnt_n        = word_bytes;
                        if (In_End_Msg) begin
                            c2_vld  = 1'b1;
                            c2      = start_c;
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = {1'b0, sum_sat};
                        if (In_End_Msg) begin
                            c1_vld     = 1'b1;
                            c1.bytes   = sum_sat;
                            c1.len_err = (sum_sat != Hdr_Length);
                            state_n    = IDLE;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // One Msg_Done per cycle: the pending close goes first, newer ones queue.
    always_comb begin
        done_n   = 1'b0;
        done_c   = pend_c_q;
        pend_n   = 1'b0;
        pend_c_n = pend_c_q;
        if (pend_q) begin
            done_n   = 1'b1;
            done_c   = pend_c_q;
            pend_n   = c1_vld;
            pend_c_n = c1;
        end else if (c1_vld) begin
            done_n   = 1'b1;
            done_c   = c1;
            pend_n   = c2_vld;
            pend_c_n = c2;
        end
    end

    // FSM state, byte counter and pending-close slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            pend_c_q <= '0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            pend_q   <= pend_n;
            pend_c_q <= pend_c_n;
        end
    end

    // Registered outputs; fields hold until their next update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Hdr_Valid    <= 1'b0;
            Hdr_Type     <= '0;
            Hdr_Flags    <= '0;
            Hdr_Length   <= '0;
            Hdr_SeqNum   <= '0;
            Msg_Done     <= 1'b0;
            Msg_Bytes    <= '0;
            Msg_LenErr   <= 1'b0;
            Msg_FrameErr <= 1'b0;
            Word_Drop    <= 1'b0;
        end else begin
            Hdr_Valid <= hdr_load;
            Msg_Done  <= done_n;
            Word_Drop <= drop_n;
            if (hdr_load) begin
                Hdr_Type   <= In_Data[63:56];
                Hdr_Flags  <= In_Data[55:48];
                Hdr_Length <= new_len;
                Hdr_SeqNum <= In_Data[31:0];
            end
            if (done_n) begin
                Msg_Bytes    <= done_c.bytes;
                Msg_LenErr   <= done_c.len_err;
                Msg_FrameErr <= done_c.frame_err;
            end
        end
    end

`ifdef MSG_HDR_STATS_EN
    logic [1:0] err_inc;
    assign err_inc = {1'b0, done_n & (done_c.len_err | done_c.frame_err)} + {1'b0, drop_n};

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Stat_MsgCount <= '0;
            Stat_ErrCount <= '0;
        end else begin
            if (done_n && (Stat_MsgCount != 16'hFFFF))
                Stat_MsgCount <= Stat_MsgCount + 16'd1;
            Stat_ErrCount <= sat16({1'b0, Stat_ErrCount} + {15'd0, err_inc});
        end
    end
`else
    assign Stat_MsgCount = '0;
    assign Stat_ErrCount = '0;
`endif

endmodule

// File: tb/tb_msg_header_decoder.sv
// tb_msg_header_decoder: directed plus randomized stimulus against a
// message-level reference model (close events kept in a queue).
module tb_msg_header_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        In_Valid = 1'b0, In_Start_Msg = 1'b0, In_End_Msg = 1'b0;
    logic [2:0]  In_Mod = '0;
    logic [63:0] In_Data = '0;
    logic        Hdr_Valid, Msg_Done, Msg_LenErr, Msg_FrameErr, Word_Drop;
    logic [7:0]  Hdr_Type, Hdr_Flags;
    logic [15:0] Hdr_Length, Msg_Bytes, Stat_MsgCount, Stat_ErrCount;
    logic [31:0] Hdr_SeqNum;

    msg_header_decoder #(.WordWidth(64), .Bits(3)) dut (
        .clk(clk), .reset(reset),
        .In_Valid(In_Valid), .In_Start_Msg(In_Start_Msg), .In_End_Msg(In_End_Msg),
        .In_Mod(In_Mod), .In_Data(In_Data),
        .Hdr_Valid(Hdr_Valid), .Hdr_Type(Hdr_Type), .Hdr_Flags(Hdr_Flags),
        .Hdr_Length(Hdr_Length), .Hdr_SeqNum(Hdr_SeqNum),
        .Msg_Done(Msg_Done), .Msg_Bytes(Msg_Bytes), .Msg_LenErr(Msg_LenErr),
        .Msg_FrameErr(Msg_FrameErr), .Word_Drop(Word_Drop),
        .Stat_MsgCount(Stat_MsgCount), .Stat_ErrCount(Stat_ErrCount)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // reference model state
    typedef struct {int bytes; bit lenerr; bit frame;} cl_t;
    cl_t q[$];
    bit  m_open;
    int  m_bytes, m_len;
    bit  e_hv, e_done, e_drop, e_lenerr, e_frame;
    logic [7:0]  e_type, e_flags;
    logic [15:0] e_len, e_bytes;
    logic [31:0] e_seq;
    int  e_msgc, e_errc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_open = 0; m_bytes = 0; m_len = 0;
        e_hv = 0; e_done = 0; e_drop = 0; e_lenerr = 0; e_frame = 0;
        e_type = 0; e_flags = 0; e_len = 0; e_bytes = 0; e_seq = 0;
        e_msgc = 0; e_errc = 0;
    endtask

    task automatic push_close(input bit frame);
        cl_t c;
        c.bytes = m_bytes; c.lenerr = (m_bytes != m_len); c.frame = frame;
        q.push_back(c);
    endtask

    task automatic model_step(input bit v, input bit s, input bit e,
                              input bit [2:0] mod, input bit [63:0] d);
        int wb;
        cl_t c;
        e_hv = 0; e_done = 0; e_drop = 0;
        if (v) begin
            wb = (e && mod != 0) ? int'(mod) : 8;
            if (s) begin
                if (m_open) push_close(1);
                e_hv = 1; e_type = d[63:56]; e_flags = d[55:48];
                e_len = d[47:32]; e_seq = d[31:0];
                m_len = int'(d[47:32]); m_bytes = wb; m_open = 1;
                if (e) begin push_close(0); m_open = 0; end
            end else if (m_open) begin
                m_bytes = (m_bytes + wb > 65535) ? 65535 : m_bytes + wb;
                if (e) begin push_close(0); m_open = 0; end
            end else begin
                e_drop = 1;
            end
        end
        if (q.size() > 0) begin
            c = q.pop_front();
            e_done = 1; e_bytes = 16'(c.bytes); e_lenerr = c.lenerr; e_frame = c.frame;
        end
`ifdef MSG_HDR_STATS_EN
        if (e_done && e_msgc < 65535) e_msgc++;
        e_errc += int'(e_done && (e_lenerr || e_frame)) + int'(e_drop);
        if (e_errc > 65535) e_errc = 65535;
`endif
    endtask

    task automatic compare_all();
        chk("hdr_valid", 64'(Hdr_Valid), 64'(e_hv));
        chk("hdr_type", 64'(Hdr_Type), 64'(e_type));
        chk("hdr_flags", 64'(Hdr_Flags), 64'(e_flags));
        chk("hdr_length", 64'(Hdr_Length), 64'(e_len));
        chk("hdr_seqnum", 64'(Hdr_SeqNum), 64'(e_seq));
        chk("msg_done", 64'(Msg_Done), 64'(e_done));
        chk("msg_bytes", 64'(Msg_Bytes), 64'(e_bytes));
        chk("msg_lenerr", 64'(Msg_LenErr), 64'(e_lenerr));
        chk("msg_frameerr", 64'(Msg_FrameErr), 64'(e_frame));
        chk("word_drop", 64'(Word_Drop), 64'(e_drop));
        chk("stat_msgcount", 64'(Stat_MsgCount), 64'(e_msgc));
        chk("stat_errcount", 64'(Stat_ErrCount), 64'(e_errc));
    endtask

    task automatic cyc(input bit v, input bit s, input bit e,
                       input bit [2:0] mod, input bit [63:0] d);
        In_Valid = v; In_Start_Msg = s; In_End_Msg = e; In_Mod = mod; In_Data = d;
        @(posedge clk);
        model_step(v, s, e, mod, d);
        #1;
        compare_all();
    endtask

    task automatic idle();
        cyc(0, 1'($urandom), 1'($urandom), 3'($urandom), {$urandom, $urandom});
    endtask

    function automatic bit [63:0] hdr(input bit [7:0] t, input bit [7:0] f,
                                      input bit [15:0] len, input bit [31:0] seq);
        return {t, f, len, seq};
    endfunction

    // one random message; optionally left open so the next Start aborts it
    task automatic rand_msg(input bit abort);
        int n, total;
        bit [2:0] mod;
        bit [15:0] len;
        n = $urandom_range(1, 6);
        mod = 3'($urandom);
        total = 8 * (n - 1) + ((mod == 0) ? 8 : int'(mod));
        len = ($urandom_range(0, 2) != 0) ? 16'(total) : 16'($urandom_range(0, 60));
        if (abort && n == 1) n = 2;
        for (int i = 0; i < n; i++) begin
            if (abort && i == n - 1) break;
            cyc(1, i == 0, i == n - 1, (i == n - 1) ? mod : 3'($urandom),
                (i == 0) ? hdr(8'($urandom), 8'($urandom), len, $urandom)
                         : {$urandom, $urandom});
            if ($urandom_range(0, 9) == 0) idle();
        end
    endtask

    initial begin
        model_reset();
        #2;
        compare_all();                       // reset state
        @(negedge clk); reset = 1'b1;

        // stray word from IDLE
        cyc(1, 0, 0, 3'd0, 64'hDEAD_BEEF_0000_0001);
        chk("drop_pulse", 64'(Word_Drop), 64'd1);
`ifdef MSG_HDR_STATS_EN
        chk("drop_errcount", 64'(Stat_ErrCount), 64'd1);
        chk("drop_msgcount", 64'(Stat_MsgCount), 64'd0);
`endif
        idle();

        // single-word message
        cyc(1, 1, 1, 3'd0, 64'h1102_0008_0000_0007);
        chk("sw_type", 64'(Hdr_Type), 64'h11);
        chk("sw_len", 64'(Hdr_Length), 64'd8);
        chk("sw_done", 64'(Msg_Done), 64'd1);
        chk("sw_bytes", 64'(Msg_Bytes), 64'd8);
        chk("sw_lenerr", 64'(Msg_LenErr), 64'd0);

        // three words, Mod=3, length 19 then 20 (back to back)
        cyc(1, 1, 0, 3'd0, hdr(8'h21, 8'h00, 16'd19, 32'd1));
        cyc(1, 0, 0, 3'd5, 64'h0);
        cyc(1, 0, 1, 3'd3, 64'h0);
        chk("m3_bytes", 64'(Msg_Bytes), 64'd19);
        chk("m3_lenerr", 64'(Msg_LenErr), 64'd0);
        cyc(1, 1, 0, 3'd0, hdr(8'h22, 8'h00, 16'd20, 32'd2));
        cyc(1, 0, 0, 3'd0, 64'h0);
        cyc(1, 0, 1, 3'd3, 64'h0);
        chk("m3b_lenerr", 64'(Msg_LenErr), 64'd1);

        // abort by a single-word Start
        cyc(1, 1, 0, 3'd0, hdr(8'h31, 8'h00, 16'd16, 32'd3));
        cyc(1, 0, 0, 3'd0, 64'h0);
        cyc(1, 1, 1, 3'd0, hdr(8'h32, 8'h01, 16'd8, 32'd4));
        chk("ab_done", 64'(Msg_Done), 64'd1);
        chk("ab_frame", 64'(Msg_FrameErr), 64'd1);
        chk("ab_bytes", 64'(Msg_Bytes), 64'd16);
        chk("ab_hdr", 64'(Hdr_Valid), 64'd1);
        idle();
        chk("ab2_done", 64'(Msg_Done), 64'd1);
        chk("ab2_bytes", 64'(Msg_Bytes), 64'd8);
        chk("ab2_frame", 64'(Msg_FrameErr), 64'd0);

        // saturation: 9000 full words
        cyc(1, 1, 0, 3'd0, hdr(8'h41, 8'h00, 16'h1234, 32'd5));
        for (int i = 0; i < 8998; i++) cyc(1, 0, 0, 3'($urandom), {$urandom, $urandom});
        cyc(1, 0, 1, 3'd0, 64'h0);
        chk("sat_bytes", 64'(Msg_Bytes), 64'hFFFF);
        chk("sat_lenerr", 64'(Msg_LenErr), 64'd1);

        // asynchronous reset mid-message
        cyc(1, 1, 0, 3'd0, hdr(8'h51, 8'h00, 16'd24, 32'd6));
        cyc(1, 0, 0, 3'd0, 64'h0);
        #2 reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk); reset = 1'b1;
        idle();
        chk("rst_nodone", 64'(Msg_Done), 64'd0);
        cyc(1, 1, 0, 3'd0, hdr(8'h61, 8'h00, 16'd12, 32'd7));
        cyc(1, 0, 1, 3'd4, 64'h0);
        chk("rst_next_bytes", 64'(Msg_Bytes), 64'd12);

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 9))
                0:       cyc(1, 0, 1'($urandom), 3'($urandom), {$urandom, $urandom});
                1:       idle();
                2:       rand_msg(1);
                default: rand_msg(0);
            endcase
        end
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/msg_header_decoder.md
# msg_header_decoder

Decodes the parsed message stream emitted by the message-parsing core (OutBus_Valid/Start_Msg/End_Msg/Mod/Data) into header fields and per-message status. Sits directly downstream of the parser output bus. It latches the fixed header carried in the first word of each message and counts payload bytes through End_Msg. At message end it reports the byte count and length and framing errors to the strategy/logging logic. The input has no back-pressure, so the block accepts every valid word in the cycle it is presented.

## Interface

Parameters:
- WordWidth, 64, data word width in bits; header layout requires exactly 64
- Bits, 3, width of the Mod field; log2(WordWidth/8)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- In_Valid  in  1  word valid on In_Data this cycle
- In_Start_Msg  in  1  first word of a message; qualified by In_Valid
- In_End_Msg  in  1  last word of a message; qualified by In_Valid
- In_Mod  in  Bits  valid bytes in the End word; 0 = all 8 valid; ignored on non-End words
- In_Data  in  WordWidth  message word; byte 0 = In_Data[63:56]
- Hdr_Valid  out  1  one-cycle pulse: header fields updated
- Hdr_Type  out  8  header byte 0
- Hdr_Flags  out  8  header byte 1
- Hdr_Length  out  16  declared message length in bytes (bytes 2..3, big-endian)
- Hdr_SeqNum  out  32  sequence number (bytes 4..7, big-endian)
- Msg_Done  out  1  one-cycle pulse: message closed
- Msg_Bytes  out  16  bytes received in the closed message, saturating at 0xFFFF
- Msg_LenErr  out  1  valid with Msg_Done: Msg_Bytes != Hdr_Length of that message
- Msg_FrameErr  out  1  valid with Msg_Done: message aborted by a new Start before End
- Word_Drop  out  1  one-cycle pulse: valid word seen outside a message and discarded
- Stat_MsgCount  out  16  closed-message counter (see Configuration)
- Stat_ErrCount  out  16  errored-message counter (see Configuration)

## Operation

- States: IDLE (no open message) and BODY (message open).
- IDLE, In_Valid & In_Start_Msg:
  - Latch the header fields and pulse Hdr_Valid.
  - Byte counter := 8, or the End-word count if In_End_Msg is also set.
  - With In_End_Msg: close the message immediately and stay in IDLE. Otherwise go to BODY.
- IDLE, In_Valid & !In_Start_Msg: pulse Word_Drop; no other state change.
- BODY, In_Valid & !In_Start_Msg:
  - Byte counter += 8, or += (In_Mod==0 ? 8 : In_Mod) on an End word.
  - On In_End_Msg: close the message and go to IDLE.
- BODY, In_Valid & In_Start_Msg:
  - Close the current message with Msg_FrameErr=1, without adding this word's bytes to it.
  - In the same cycle, start a new message from this word as in IDLE, including the single-word case.
- Close:
  - Msg_Bytes := final counter, saturating at 0xFFFF.
  - Msg_LenErr := (Msg_Bytes != latched Hdr_Length).
  - Msg_FrameErr as above; pulse Msg_Done.
- In_Valid=0: no state change; In_Start_Msg, In_End_Msg and In_Mod are ignored.
- The byte counter is 17 bits internally; it saturates at 0xFFFF and does not wrap.
- Hdr_* and Msg_Bytes/LenErr/FrameErr hold their values until the next update.

## Timing

- All outputs are registered. Latency is 1 cycle from the input word to the corresponding pulse.
- Hdr_Valid, Msg_Done and Word_Drop are high for exactly one cycle per event.
- A single-word message gives Hdr_Valid and Msg_Done in the same cycle.
- An aborting Start gives Msg_Done (FrameErr=1, old message's bytes) and Hdr_Valid (new header) in the same cycle.
- Back-to-back messages are accepted with no idle cycle: End word at cycle N, next Start word at cycle N+1.
- Reset (reset=0, asynchronous):
  - State := IDLE; all outputs := 0, including the counters.
  - Any open message is discarded with no Msg_Done.
  - The first clk edge after reset release is a normal cycle.

## Configuration

- MSG_HDR_STATS_EN defined:
  - Stat_MsgCount increments on every Msg_Done.
  - Stat_ErrCount increments on Msg_Done with LenErr or FrameErr set, and on each Word_Drop.
  - Both counters are 16-bit, saturate at 0xFFFF and reset to 0.
- MSG_HDR_STATS_EN undefined: the ports remain, tied to 0; no counter logic is built.

## Test plan

- Single-word message, Data=0x11_02_0008_0000_0007, Mod=0 -> next cycle Hdr_Valid=1, Type=0x11, Flags=0x02, Length=8, SeqNum=7; Msg_Done=1, Msg_Bytes=8, LenErr=0.
- Three-word message, Length=0x0013, End word Mod=3 -> Msg_Done 1 cycle after the End word; Msg_Bytes=19, LenErr=0. Repeat with Length=20 -> LenErr=1.
- Start, one body word, then a new Start with Length=8 and End set -> in one cycle: Msg_Done with FrameErr=1 and Msg_Bytes=16, plus Hdr_Valid for the new header; the following cycle Msg_Done with Msg_Bytes=8 and FrameErr=0.
- Valid word with no Start while in IDLE -> Word_Drop pulses once, no Hdr_Valid or Msg_Done. With MSG_HDR_STATS_EN: Stat_ErrCount=1, Stat_MsgCount=0.
- 9000 full words in one message -> Msg_Bytes=0xFFFF (saturated) and LenErr=1. Separately, assert reset mid-message -> all outputs 0 immediately, no Msg_Done; the next message decodes correctly.
